// File: rtl/vga_sync_decoder.sv
// VGA timing decoder: locks to incoming hsync/vsync/blank timing and captures
// active pixels with their (x, y) coordinates once the timing has proven stable.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank,
  input  logic [7:0] color_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] pixel,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam int          GW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0]  H_TARGET = 10'(H_ACTIVE);
  localparam logic [9:0]  V_TARGET = 10'(V_ACTIVE);
  localparam logic [9:0]  CNT_MAX  = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t        state;
  logic          hs_q, vs_q;
  logic [9:0]    hcnt, vcnt;
  logic [GW-1:0] good_frames;
  logic          bad_line_seen;

  logic          h_fall, v_fall, active_line, line_bad, frame_good, capture;
  logic [9:0]    vcnt_eff;

  // The frame check sees the row count as if the coincident line check had
  // already been applied, so a line ending on the vsync edge still counts.
  // NOTE: every signal gets a value on every path here, so no latch can form.
  always_comb begin
    h_fall      = pix_en & hs_q & ~hsync;
    v_fall      = pix_en & vs_q & ~vsync;
    active_line = h_fall && (hcnt != '0);
    line_bad    = active_line && (hcnt != H_TARGET);
    vcnt_eff    = (active_line && vcnt != CNT_MAX) ? vcnt + 10'd1 : vcnt;
    frame_good  = (vcnt_eff == V_TARGET) && !bad_line_seen && !line_bad;
    capture     = pix_en && blank && (state == LOCKED) &&
                  (hcnt < H_TARGET) && (vcnt < V_TARGET);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hcnt          <= '0;
      vcnt          <= '0;
      good_frames   <= '0;
      bad_line_seen <= 1'b0;
      locked        <= 1'b0;
      pixel_valid   <= 1'b0;
      frame_start   <= 1'b0;
      x             <= '0;
      y             <= '0;
      pixel         <= '0;
      err_count     <= '0;
    end else begin
      pixel_valid <= capture;
      frame_start <= 1'b0;

      if (capture) begin
        x     <= hcnt;
        y     <= vcnt;
        pixel <= color_in;
      end

      if (pix_en) begin
        hs_q <= hsync;
        vs_q <= vsync;

        if (h_fall)                       hcnt <= '0;
        else if (blank && hcnt != CNT_MAX) hcnt <= hcnt + 10'd1;

        if (v_fall)                                     vcnt <= '0;
        else if (active_line && vcnt != CNT_MAX)        vcnt <= vcnt + 10'd1;

        if (v_fall)        bad_line_seen <= 1'b0;
        else if (line_bad) bad_line_seen <= 1'b1;
      end

      unique case (state)
        SEARCH: begin
          if (v_fall) begin
            good_frames <= '0;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (line_bad || (v_fall && !frame_good)) begin
            good_frames <= '0;
            state       <= SEARCH;
          end else if (v_fall) begin
            good_frames <= good_frames + 1'b1;
            if (good_frames == GW'(LOCK_FRAMES - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (v_fall && !frame_good)) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            good_frames <= '0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else if (v_fall) begin
            frame_start <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 8x6 raster
// (12 samples per line, 10 lines per frame) with hand-computed expectations.
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int VA = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       pix_en, hsync, vsync, blank;
  logic [7:0] color_in;
  logic [9:0] x, y;
  logic [7:0] pixel, err_count;
  logic       pixel_valid, frame_start, locked;

  int n_checks = 0;
  int n_pass   = 0;

  int   n_pix = 0, n_over = 0, n_fs = 0;
  int   last_x = 0, last_y = 0, last_pix = 0;
  bit   mon_en = 1'b0;
  int   p0, f0, o0;

  vga_sync_decoder #(.H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en), .hsync(hsync),
    .vsync(vsync), .blank(blank), .color_in(color_in), .x(x), .y(y),
    .pixel(pixel), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .locked(locked), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // One pixel sample: inputs valid for the pix_en clock, noise on the idle clock.
  task automatic drive(input logic hs, input logic vs, input logic bl, input logic [7:0] col);
    @(negedge clock);
    hsync = hs; vsync = vs; blank = bl; color_in = col; pix_en = 1'b1;
    @(negedge clock);
    pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0; blank = 1'b1; color_in = 8'hAA;
  endtask

  // Line: pixels at samples 0..7, hsync low at 9..10. Frame: vsync low on lines
  // 7..8, or (simul) from line 5 sample 9 so it falls together with hsync.
  task automatic send_frame(input int n_act, input int short_line, input bit simul,
                            input bit probe, input int n_lines);
    logic hs, vs, bl;
    logic [7:0] col;
    int act_len;
    for (int ln = 0; ln < n_lines; ln++) begin
      for (int s = 0; s < 12; s++) begin
        act_len = (ln == short_line) ? HA - 1 : HA;
        bl  = (ln < n_act) && (s < act_len);
        hs  = !(s == 9 || s == 10);
        if (simul) vs = !((ln == 5 && s >= 9) || ln == 6 || ln == 7 || ln == 8);
        else       vs = !(ln == 7 || ln == 8);
        col = bl ? 8'(s + 16 * ln) : 8'h00;
        if (probe && ln == short_line && s == 9) check("lock_before_short_hs", 32'(locked), 1);
        drive(hs, vs, bl, col);
        if (probe && ln == short_line && s == 9) begin
          check("lock_after_short_hs", 32'(locked), 0);
          check("err_after_short_hs", 32'(err_count), 1);
        end
      end
    end
  endtask

  // Output monitor: pulse widths, capture counts and raster-order scoreboard.
  initial begin : monitor
    bit prev_pv = 1'b0, prev_fs = 1'b0;
    int exp_x = 0, exp_y = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin exp_x = 0; exp_y = 0; end
      if (pixel_valid) begin
        check("pixel_valid_width", 32'(prev_pv), 0);
        n_pix++;
        if (x >= HA || y >= VA) n_over++;
        last_x = int'(x); last_y = int'(y); last_pix = int'(pixel);
        if (mon_en) begin
          check("pix_yx_color", 32'({y, x, pixel}),
                32'({10'(exp_y), 10'(exp_x), 8'(exp_x + 16 * exp_y)}));
          exp_x++;
          if (exp_x == HA) begin exp_x = 0; exp_y++; end
        end
      end
      if (frame_start) begin
        check("frame_start_width", 32'(prev_fs), 0);
        n_fs++;
      end
      prev_pv = pixel_valid;
      prev_fs = frame_start;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    reset = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; blank = 1'b0; color_in = '0;
    repeat (3) @(negedge clock);
    check("rst_locked", 32'(locked), 0);
    check("rst_pixel_valid", 32'(pixel_valid), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_xy_pixel", 32'({x, y, pixel}), 0);
    check("rst_err", 32'(err_count), 0);
    reset = 1'b1;

    // Sync frame plus two good frames lock the decoder.
    send_frame(VA, -1, 0, 0, 10);
    check("lock_after_f1", 32'(locked), 0);
    send_frame(VA, -1, 0, 0, 10);
    check("lock_after_f2", 32'(locked), 0);
    send_frame(VA, -1, 0, 0, 10);
    check("lock_after_f3", 32'(locked), 1);
    check("err_after_lock", 32'(err_count), 0);
    check("fs_before_lock", n_fs, 0);

    // Full locked frame: 48 pixels in raster order, one frame_start.
    p0 = n_pix; f0 = n_fs; mon_en = 1'b1;
    send_frame(VA, -1, 0, 0, 10);
    mon_en = 1'b0;
    check("frame_pix_count", n_pix - p0, HA * VA);
    check("last_x", last_x, 7);
    check("last_y", last_y, 5);
    check("last_pixel", last_pix, 87);
    check("frame_fs_count", n_fs - f0, 1);
    check("lock_full_frame", 32'(locked), 1);

    // Short line (7 pixels) on line 2 while locked, then relock.
    p0 = n_pix; f0 = n_fs;
    send_frame(VA, 2, 0, 1, 10);
    check("short_lock_f5", 32'(locked), 0);
    send_frame(VA, -1, 0, 0, 10);
    check("relock_f6", 32'(locked), 0);
    send_frame(VA, -1, 0, 0, 10);
    check("relock_f7", 32'(locked), 1);
    check("short_pix_count", n_pix - p0, 23);
    check("short_fs_count", n_fs - f0, 0);
    check("short_err", 32'(err_count), 1);

    // Seven active lines: row 6 never captured, lock lost at vsync.
    p0 = n_pix; f0 = n_fs; o0 = n_over;
    send_frame(VA + 1, -1, 0, 0, 10);
    check("tall_lock", 32'(locked), 0);
    check("tall_err", 32'(err_count), 2);
    check("tall_pix_count", n_pix - p0, 48);
    check("tall_overrun", n_over - o0, 0);
    check("tall_fs_count", n_fs - f0, 0);
    send_frame(VA, -1, 0, 0, 10);
    send_frame(VA, -1, 0, 0, 10);
    check("relock_f10", 32'(locked), 0);
    send_frame(VA, -1, 0, 0, 10);
    check("relock_f11", 32'(locked), 1);

    // Coincident hsync/vsync edges: good last line keeps lock, short one loses it.
    p0 = n_pix; f0 = n_fs;
    send_frame(VA, -1, 1, 0, 10);
    check("simul_good_lock", 32'(locked), 1);
    check("simul_good_fs", n_fs - f0, 1);
    check("simul_good_err", 32'(err_count), 2);
    send_frame(VA, 5, 1, 0, 10);
    check("simul_short_lock", 32'(locked), 0);
    check("simul_short_err", 32'(err_count), 3);
    check("simul_short_fs", n_fs - f0, 1);
    check("simul_pix_count", n_pix - p0, 95);

    // Relock, stop mid-frame, reset asynchronously and relock from scratch.
    repeat (3) send_frame(VA, -1, 0, 0, 10);
    check("pre_reset_lock", 32'(locked), 1);
    send_frame(VA, -1, 0, 0, 3);
    check("hold_x", 32'(x), 7);
    check("hold_y", 32'(y), 2);
    check("hold_pixel", 32'(pixel), 39);
    check("pre_reset_err", 32'(err_count), 3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_pv_fs", 32'({pixel_valid, frame_start}), 0);
    check("mid_rst_xy_pixel", 32'({x, y, pixel}), 0);
    check("mid_rst_err", 32'(err_count), 0);
    @(negedge clock);
    reset = 1'b1;
    send_frame(VA, -1, 0, 0, 10);
    check("post_rst_f1", 32'(locked), 0);
    send_frame(VA, -1, 0, 0, 10);
    check("post_rst_f2", 32'(locked), 0);
    send_frame(VA, -1, 0, 0, 10);
    check("post_rst_f3", 32'(locked), 1);
    check("post_rst_err", 32'(err_count), 0);

    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
